// File: rtl/scope_trigger_capture.sv
// Trigger-and-capture stage for the ADC front end. Samples stream into a circular
// buffer; a level crossing (or a forced trigger) ends the pre-trigger phase and a
// fixed number of post-trigger samples completes the window, which is then frozen
// for random-access readout relative to the oldest sample of the window.
module scope_trigger_capture #(
   parameter int DATA_W   = 12,
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 8,
   parameter int PRE_TRIG = 64
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [DATA_W-1:0] i_sample,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_trig_level,
   input  logic              i_trig_rising,
   input  logic              i_arm,
   input  logic              i_force,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_busy,
   output logic              o_triggered,
   output logic              o_done
);

   localparam int CNT_W  = ADDR_W + 1;
   localparam int POST_N = DEPTH - PRE_TRIG;

   localparam logic [ADDR_W-1:0] PRE_LAST     = ADDR_W'(PRE_TRIG - 1);
   localparam logic [CNT_W-1:0]  POST_LAST_M1 = CNT_W'(POST_N - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StWait,
      StPost,
      StDone
   } state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [ADDR_W-1:0]   r_wp;
   logic [ADDR_W-1:0]   w_wp_nxt;
   logic [ADDR_W-1:0]   r_start;
   logic [ADDR_W-1:0]   w_start_nxt;
   logic [DATA_W-1:0]   r_prev;
   logic [DATA_W-1:0]   w_prev_nxt;
   logic                r_prev_ok;
   logic                w_prev_ok_nxt;
   logic                r_force_pend;
   logic                w_force_pend_nxt;
   logic [ADDR_W-1:0]   r_pre_cnt;
   logic [ADDR_W-1:0]   w_pre_cnt_nxt;
   logic [CNT_W-1:0]    r_post_cnt;
   logic [CNT_W-1:0]    w_post_cnt_nxt;
   logic                r_busy;
   logic                r_triggered;
   logic                r_done;
   logic [DATA_W-1:0]   r_rd_data;

   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_capturing;
   logic                w_accept;
   logic                w_cross;
   logic                w_trig;
   logic [ADDR_W-1:0]   w_wp_inc;
   logic [ADDR_W-1:0]   w_rd_idx;

   // A sample in the arm cycle is dropped so the new capture starts clean.
   assign w_capturing = (r_state == StPre) || (r_state == StWait) || (r_state == StPost);
   assign w_accept    = i_sample_valid && !i_arm && w_capturing;
   assign w_wp_inc    = r_wp + 1'b1;
   assign w_rd_idx    = r_start + i_rd_addr;

   // Level-crossing detector against the previous accepted sample.
   always_comb begin
      w_cross = 1'b0;
      if (i_trig_rising) begin
         w_cross = (r_prev < i_trig_level) && (i_sample >= i_trig_level);
      end else begin
         w_cross = (r_prev > i_trig_level) && (i_sample <= i_trig_level);
      end
   end

   assign w_trig = (r_state == StWait) && w_accept && (r_force_pend || (r_prev_ok && w_cross));

   // Next-state and datapath update; arm overrides everything, including force.
   always_comb begin
      w_state_nxt      = r_state;
      w_wp_nxt         = r_wp;
      w_start_nxt      = r_start;
      w_prev_nxt       = r_prev;
      w_prev_ok_nxt    = r_prev_ok;
      w_force_pend_nxt = r_force_pend;
      w_pre_cnt_nxt    = r_pre_cnt;
      w_post_cnt_nxt   = r_post_cnt;

      if (w_accept) begin
         w_wp_nxt = w_wp_inc;
      end

      if (i_arm) begin
         w_state_nxt      = StPre;
         w_prev_ok_nxt    = 1'b0;
         w_force_pend_nxt = 1'b0;
         w_pre_cnt_nxt    = '0;
         w_post_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               w_state_nxt = r_state;
            end
            StPre: begin
               if (i_force) begin
                  w_force_pend_nxt = 1'b1;
               end
               if (w_accept) begin
                  w_prev_nxt    = i_sample;
                  w_prev_ok_nxt = 1'b1;
                  if (r_pre_cnt == PRE_LAST) begin
                     w_state_nxt = StWait;
                  end else begin
                     w_pre_cnt_nxt = r_pre_cnt + 1'b1;
                  end
               end
            end
            StWait: begin
               if (i_force) begin
                  w_force_pend_nxt = 1'b1;
               end
               if (w_accept) begin
                  w_prev_nxt    = i_sample;
                  w_prev_ok_nxt = 1'b1;
               end
               if (w_trig) begin
                  // The trigger sample is post sample 1; a single-sample post
                  // phase completes the window right here.
                  w_force_pend_nxt = 1'b0;
                  w_post_cnt_nxt   = CNT_W'(1);
                  if (POST_N == 1) begin
                     w_state_nxt = StDone;
                     w_start_nxt = w_wp_inc;
                  end else begin
                     w_state_nxt = StPost;
                  end
               end
            end
            StPost: begin
               if (w_accept) begin
                  if (r_post_cnt == POST_LAST_M1) begin
                     w_state_nxt = StDone;
                     w_start_nxt = w_wp_inc;
                  end else begin
                     w_post_cnt_nxt = r_post_cnt + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = StIdle;
            end
         endcase
      end
   end

   // Control and datapath registers; status flags are registered decodes of next state.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_wp         <= '0;
         r_start      <= '0;
         r_prev       <= '0;
         r_prev_ok    <= 1'b0;
         r_force_pend <= 1'b0;
         r_pre_cnt    <= '0;
         r_post_cnt   <= '0;
         r_busy       <= 1'b0;
         r_triggered  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wp         <= w_wp_nxt;
         r_start      <= w_start_nxt;
         r_prev       <= w_prev_nxt;
         r_prev_ok    <= w_prev_ok_nxt;
         r_force_pend <= w_force_pend_nxt;
         r_pre_cnt    <= w_pre_cnt_nxt;
         r_post_cnt   <= w_post_cnt_nxt;
         r_busy       <= (w_state_nxt == StPre) || (w_state_nxt == StWait) ||
                         (w_state_nxt == StPost);
         r_triggered  <= (w_state_nxt == StPost) || (w_state_nxt == StDone);
         r_done       <= (w_state_nxt == StDone);
      end
   end

   // Sample buffer write port; contents are not reset.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_mem[r_wp] <= i_sample;
      end
   end

   // Registered read port, addressed relative to the oldest sample of the window.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[w_rd_idx];
      end
   end

   assign o_rd_data   = r_rd_data;
   assign o_busy      = r_busy;
   assign o_triggered = r_triggered;
   assign o_done      = r_done;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Self-checking bench for scope_trigger_capture: directed scenarios plus randomized
// captures, all checked against a sample-list model of the capture window.
module tb_scope_trigger_capture;

   localparam int PRE  = 64;
   localparam int DEP  = 256;
   localparam int POST = DEP - PRE;

   logic        i_clk;
   logic        i_reset_n;
   logic [11:0] i_sample;
   logic        i_sample_valid;
   logic [11:0] i_trig_level;
   logic        i_trig_rising;
   logic        i_arm;
   logic        i_force;
   logic [7:0]  i_rd_addr;
   logic [11:0] o_rd_data;
   logic        o_busy;
   logic        o_triggered;
   logic        o_done;

   int total;
   int bad;

   // Model: every sample accepted since the last arm, plus trigger position.
   logic [11:0] cap[$];
   bit          m_armed;
   bit          m_trig;
   bit          m_done;
   bit          m_fp;
   int          m_tidx;

   scope_trigger_capture #(
      .DATA_W   (12),
      .DEPTH    (DEP),
      .ADDR_W   (8),
      .PRE_TRIG (PRE)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .i_trig_level   (i_trig_level),
      .i_trig_rising  (i_trig_rising),
      .i_arm          (i_arm),
      .i_force        (i_force),
      .i_rd_addr      (i_rd_addr),
      .o_rd_data      (o_rd_data),
      .o_busy         (o_busy),
      .o_triggered    (o_triggered),
      .o_done         (o_done)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic bit m_cross(input logic [11:0] p, input logic [11:0] s);
      if (i_trig_rising) return (p < i_trig_level) && (s >= i_trig_level);
      return (p > i_trig_level) && (s <= i_trig_level);
   endfunction

   function automatic logic [2:0] m_flags();
      return {m_armed && !m_done, m_trig, m_done};
   endfunction

   function automatic logic [11:0] m_win(input int off);
      return cap[m_tidx - PRE + off];
   endfunction

   task automatic model_reset();
      m_armed = 0; m_trig = 0; m_done = 0; m_fp = 0; m_tidx = 0;
      cap.delete();
   endtask

   // Applies one clock edge worth of inputs to the model.
   task automatic model_edge();
      bit hit;
      bit open;
      int n;
      hit = 0;
      if (i_arm) begin
         m_armed = 1; m_trig = 0; m_done = 0; m_fp = 0;
         cap.delete();
      end else if (m_armed && !m_done) begin
         open = !m_trig;
         if (i_sample_valid) begin
            n = cap.size();
            if (!m_trig && n >= PRE) hit = m_fp || m_cross(cap[n-1], i_sample);
            cap.push_back(i_sample);
            if (hit) begin
               m_trig = 1; m_tidx = n; m_fp = 0;
            end
         end
         if (i_force && open && !hit) m_fp = 1;
         if (m_trig && cap.size() == m_tidx + POST) m_done = 1;
      end
   endtask

   task automatic drive_cycle(input logic v, input logic [11:0] s, input logic a,
                              input logic f);
      i_sample_valid = v; i_sample = s; i_arm = a; i_force = f;
      @(posedge i_clk);
      model_edge();
      #1;
      i_sample_valid = 1'b0; i_arm = 1'b0; i_force = 1'b0;
   endtask

   task automatic read_off(input int off, output logic [11:0] d);
      i_rd_addr = off[7:0];
      @(posedge i_clk);
      #1;
      d = o_rd_data;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      #12;
      total += 4;
      if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      if (o_triggered !== 1'b0) begin bad++; $display("FAIL reset_trig: got %b want 0", o_triggered); end
      if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
      if (o_rd_data !== 12'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", o_rd_data); end
      @(negedge i_clk);
      i_reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 12'd3000, 1'b0, 1'b0);
         total++;
         if ({o_busy, o_triggered, o_done} !== 3'b000) begin
            bad++; $display("FAIL idle_ignores_sample: got %b want 000", {o_busy, o_triggered, o_done});
         end
      end
   endtask

   task automatic test_rising_ramp();
      int n;
      int cyc;
      logic [11:0] d;
      i_trig_level = 12'd2048; i_trig_rising = 1'b1;
      drive_cycle(1'b0, 12'd0, 1'b1, 1'b0);
      total++;
      if ({o_busy, o_triggered, o_done} !== 3'b100) begin
         bad++; $display("FAIL ramp_arm_flags: got %b want 100", {o_busy, o_triggered, o_done});
      end
      n = 0; cyc = 0;
      while (!m_done && cyc < 3000) begin
         if (cyc % 4 == 0) begin
            drive_cycle(1'b1, 12'((16 * n) % 4096), 1'b0, 1'b0);
            n++;
         end else begin
            drive_cycle(1'b0, 12'd0, 1'b0, 1'b0);
         end
         cyc++;
         total++;
         if ({o_busy, o_triggered, o_done} !== m_flags()) begin
            bad++; $display("FAIL ramp_flags n=%0d: got %b want %b", n, {o_busy, o_triggered, o_done}, m_flags());
         end
      end
      total++;
      if (n !== 320) begin bad++; $display("FAIL ramp_sample_count: got %0d want 320", n); end
      // Stream the readout: data must track the address one edge later.
      for (int k = 0; k < DEP; k++) begin
         i_rd_addr = 8'(k);
         #1;
         if (k > 0) begin
            total++;
            if (o_rd_data !== m_win(k - 1)) begin
               bad++; $display("FAIL ramp_rd_latency off=%0d: got %0d want %0d", k, o_rd_data, m_win(k - 1));
            end
         end
         @(posedge i_clk);
         #1;
         total++;
         if (o_rd_data !== m_win(k)) begin
            bad++; $display("FAIL ramp_rd off=%0d: got %0d want %0d", k, o_rd_data, m_win(k));
         end
      end
      read_off(64, d); total++;
      if (d !== 12'd2048) begin bad++; $display("FAIL ramp_off64: got %0d want 2048", d); end
      read_off(0, d); total++;
      if (d !== 12'd1024) begin bad++; $display("FAIL ramp_off0: got %0d want 1024", d); end
      read_off(255, d); total++;
      if (d !== 12'd1008) begin bad++; $display("FAIL ramp_off255: got %0d want 1008", d); end
   endtask

   task automatic test_falling_eq();
      logic [11:0] d;
      i_trig_level = 12'd50; i_trig_rising = 1'b0;
      drive_cycle(1'b0, 12'd0, 1'b1, 1'b0);
      for (int i = 0; i < PRE; i++) drive_cycle(1'b1, 12'd100, 1'b0, 1'b0);
      drive_cycle(1'b1, 12'd80, 1'b0, 1'b0);
      total++;
      if (o_triggered !== 1'b0) begin bad++; $display("FAIL fall_80_no_trig: got %b want 0", o_triggered); end
      drive_cycle(1'b1, 12'd50, 1'b0, 1'b0);
      total++;
      if ({o_busy, o_triggered, o_done} !== 3'b110) begin
         bad++; $display("FAIL fall_eq_trig: got %b want 110", {o_busy, o_triggered, o_done});
      end
      for (int i = 0; i < POST - 1; i++) begin
         total++;
         if (o_done !== 1'b0) begin bad++; $display("FAIL fall_early_done i=%0d: got 1 want 0", i); end
         drive_cycle(1'b1, 12'(i), 1'b0, 1'b0);
      end
      total++;
      if ({o_busy, o_triggered, o_done} !== 3'b011) begin
         bad++; $display("FAIL fall_done: got %b want 011", {o_busy, o_triggered, o_done});
      end
      read_off(64, d); total++;
      if (d !== 12'd50) begin bad++; $display("FAIL fall_off64: got %0d want 50", d); end
      read_off(63, d); total++;
      if (d !== 12'd80) begin bad++; $display("FAIL fall_off63: got %0d want 80", d); end
      read_off(62, d); total++;
      if (d !== 12'd100) begin bad++; $display("FAIL fall_off62: got %0d want 100", d); end
      read_off(65, d); total++;
      if (d !== 12'd0) begin bad++; $display("FAIL fall_off65: got %0d want 0", d); end
   endtask

   task automatic test_force();
      logic [11:0] d;
      i_trig_level = 12'd2048; i_trig_rising = 1'b1;
      drive_cycle(1'b0, 12'd0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) drive_cycle(1'b1, 12'd1000, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive_cycle(1'b0, 12'd0, 1'b0, 1'b0);
      total++;
      if ({o_busy, o_triggered, o_done} !== 3'b100) begin
         bad++; $display("FAIL force_stuck_wait: got %b want 100", {o_busy, o_triggered, o_done});
      end
      drive_cycle(1'b0, 12'd0, 1'b0, 1'b1);
      total++;
      if (o_triggered !== 1'b0) begin bad++; $display("FAIL force_no_sample_trig: got 1 want 0"); end
      drive_cycle(1'b1, 12'd1000, 1'b0, 1'b0);
      total++;
      if (o_triggered !== 1'b1) begin bad++; $display("FAIL force_trig: got 0 want 1"); end
      for (int i = 0; i < POST - 1; i++) begin
         total++;
         if (o_done !== 1'b0) begin bad++; $display("FAIL force_early_done i=%0d: got 1 want 0", i); end
         drive_cycle(1'b1, 12'(1001 + i), 1'b0, 1'b0);
      end
      total++;
      if (o_done !== 1'b1) begin bad++; $display("FAIL force_done: got 0 want 1"); end
      read_off(64, d); total++;
      if (d !== 12'd1000) begin bad++; $display("FAIL force_off64: got %0d want 1000", d); end
      read_off(65, d); total++;
      if (d !== 12'd1001) begin bad++; $display("FAIL force_off65: got %0d want 1001", d); end
      read_off(255, d); total++;
      if (d !== 12'd1191) begin bad++; $display("FAIL force_off255: got %0d want 1191", d); end
   endtask

   task automatic test_pre_ignored();
      logic [11:0] d;
      i_trig_level = 12'd2048; i_trig_rising = 1'b1;
      drive_cycle(1'b0, 12'd0, 1'b1, 1'b0);
      for (int i = 0; i < PRE; i++) drive_cycle(1'b1, (i < 10) ? 12'd100 : 12'd3000, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive_cycle(1'b1, 12'd3000, 1'b0, 1'b0);
      drive_cycle(1'b1, 12'd100, 1'b0, 1'b0);
      total++;
      if (o_triggered !== 1'b0) begin bad++; $display("FAIL pre_cross_ignored: got 1 want 0"); end
      drive_cycle(1'b1, 12'd3000, 1'b0, 1'b0);
      total++;
      if (o_triggered !== 1'b1) begin bad++; $display("FAIL wait_cross_trig: got 0 want 1"); end
      for (int i = 0; i < POST - 1; i++) drive_cycle(1'b1, 12'd500, 1'b0, 1'b0);
      total++;
      if (o_done !== 1'b1) begin bad++; $display("FAIL pre_ign_done: got 0 want 1"); end
      read_off(64, d); total++;
      if (d !== 12'd3000) begin bad++; $display("FAIL pre_ign_off64: got %0d want 3000", d); end
      read_off(63, d); total++;
      if (d !== 12'd100) begin bad++; $display("FAIL pre_ign_off63: got %0d want 100", d); end
      read_off(62, d); total++;
      if (d !== 12'd3000) begin bad++; $display("FAIL pre_ign_off62: got %0d want 3000", d); end
   endtask

   task automatic test_rearm();
      logic [11:0] d;
      i_trig_level = 12'd2048; i_trig_rising = 1'b1;
      drive_cycle(1'b0, 12'd0, 1'b1, 1'b0);
      for (int i = 0; i < PRE + 5; i++) drive_cycle(1'b1, 12'd100, 1'b0, 1'b0);
      drive_cycle(1'b1, 12'd3000, 1'b1, 1'b0);
      total++;
      if ({o_busy, o_triggered, o_done} !== 3'b100) begin
         bad++; $display("FAIL rearm_flags: got %b want 100", {o_busy, o_triggered, o_done});
      end
      for (int i = 0; i < PRE + 1; i++) begin
         drive_cycle(1'b1, (i % 2 == 0) ? 12'd100 : 12'd3000, 1'b0, 1'b0);
         total++;
         if (o_triggered !== 1'b0) begin bad++; $display("FAIL rearm_pre_trig i=%0d: got 1 want 0", i); end
      end
      drive_cycle(1'b1, 12'd3000, 1'b0, 1'b0);
      total++;
      if (o_triggered !== 1'b1) begin bad++; $display("FAIL rearm_trig: got 0 want 1"); end
      for (int i = 0; i < POST - 1; i++) drive_cycle(1'b1, 12'(700 + i), 1'b0, 1'b0);
      total++;
      if (o_done !== 1'b1) begin bad++; $display("FAIL rearm_done: got 0 want 1"); end
      read_off(0, d); total++;
      if (d !== 12'd3000) begin bad++; $display("FAIL rearm_off0: got %0d want 3000", d); end
      read_off(63, d); total++;
      if (d !== 12'd100) begin bad++; $display("FAIL rearm_off63: got %0d want 100", d); end
      read_off(64, d); total++;
      if (d !== 12'd3000) begin bad++; $display("FAIL rearm_off64: got %0d want 3000", d); end
      read_off(65, d); total++;
      if (d !== 12'd700) begin bad++; $display("FAIL rearm_off65: got %0d want 700", d); end
   endtask

   task automatic test_reset_mid_post();
      i_trig_level = 12'd2048; i_trig_rising = 1'b1;
      drive_cycle(1'b0, 12'd0, 1'b1, 1'b0);
      for (int i = 0; i < PRE; i++) drive_cycle(1'b1, 12'd100, 1'b0, 1'b0);
      drive_cycle(1'b1, 12'd3000, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, 12'd3000, 1'b0, 1'b0);
      i_rd_addr = 8'd64;
      @(negedge i_clk);
      i_reset_n = 1'b0;
      #1;
      total += 4;
      if (o_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", o_busy); end
      if (o_triggered !== 1'b0) begin bad++; $display("FAIL midreset_trig: got %b want 0", o_triggered); end
      if (o_done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", o_done); end
      if (o_rd_data !== 12'd0) begin bad++; $display("FAIL midreset_rd: got %0d want 0", o_rd_data); end
      model_reset();
      #1;
      i_reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b1, 12'(i * 200), 1'b0, (i == 5));
         total++;
         if ({o_busy, o_triggered, o_done} !== 3'b000) begin
            bad++; $display("FAIL post_reset_idle i=%0d: got %b want 000", i, {o_busy, o_triggered, o_done});
         end
      end
   endtask

   task automatic test_random();
      logic [11:0] d;
      int cyc;
      int t;
      int off;
      for (int r = 0; r < 4; r++) begin
         i_trig_level  = 12'($urandom_range(100, 3900));
         i_trig_rising = 1'($urandom % 2);
         drive_cycle(1'b0, 12'd0, 1'b1, 1'b0);
         cyc = 0;
         while (!m_done && cyc < 4000) begin
            t = int'(i_trig_level) + int'($urandom_range(0, 200)) - 100;
            drive_cycle(($urandom % 4) != 0, 12'(t), ($urandom % 600) == 0, ($urandom % 150) == 0);
            cyc++;
            total++;
            if ({o_busy, o_triggered, o_done} !== m_flags()) begin
               bad++; $display("FAIL rand_flags r=%0d c=%0d: got %b want %b", r, cyc, {o_busy, o_triggered, o_done}, m_flags());
            end
         end
         total++;
         if (!m_done) begin bad++; $display("FAIL rand_budget r=%0d: got not done want done", r); end
         if (m_done) begin
            for (int k = 0; k < 16; k++) begin
               off = int'($urandom_range(0, DEP - 1));
               read_off(off, d);
               total++;
               if (d !== m_win(off)) begin
                  bad++; $display("FAIL rand_rd r=%0d off=%0d: got %0d want %0d", r, off, d, m_win(off));
               end
            end
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      i_sample = '0; i_sample_valid = 1'b0; i_trig_level = '0; i_trig_rising = 1'b1;
      i_arm = 1'b0; i_force = 1'b0; i_rd_addr = '0;
      model_reset();
      test_reset();
      test_rising_ramp();
      test_falling_eq();
      test_force();
      test_pre_ignored();
      test_rearm();
      test_random();
      test_reset_mid_post();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
